regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (WrEn/Aw/Dw) between two writeback requesters: A (ALU result) and B (memory load data).
- Round-robin arbiter feeding a small in-order FIFO, followed by a registered output stage that drives the register file directly.
- Writes to register 0 are accepted and discarded, so $zero is never targeted.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- FIFO_DEPTH, 2, pending-write entries (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous reset, active-high
- a_valid  in  1  requester A has a write
- a_ready  out  1  A's write accepted this cycle
- a_addr  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- b_valid  in  1  requester B has a write
- b_ready  out  1  B's write accepted this cycle
- b_addr  in  ADDR_W  B destination register
- b_data  in  DATA_W  B write data
- wr_hold  in  1  freeze the write port (debug/stall)
- WrEn  out  1  register-file write enable (registered)
- Aw  out  ADDR_W  register-file write address (registered)
- Dw  out  DATA_W  register-file write data (registered)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries
- chk_addr  in  ADDR_W  hazard-check address (forwarding feature)
- chk_pending  out  1  chk_addr has an uncommitted write
- chk_data  out  DATA_W  youngest pending data for chk_addr

Behaviour:
- Reset (sync, has priority over all other inputs):
  - WrEn=0, Aw=0, Dw=0, fifo_count=0, read/write pointers=0, last_grant=B.
  - Reset mid-operation discards all pending writes.
- Arbitration is combinational; at most one accept per cycle.
  - If the FIFO is full, a_ready=b_ready=0.
  - Otherwise, a single valid requester is granted.
  - If both are valid, the requester other than last_grant is granted.
  - last_grant updates on every accept, including discarded addr-0 writes.
  - ready never depends on wr_hold or on the same-cycle pop (no combinational path).
  - The first contested cycle after reset grants A.
- Accept (valid & ready at posedge):
  - addr!=0: push {addr,data} into the FIFO.
  - addr==0: consume with no push and no later WrEn.
- Output stage, at each posedge:
  - If !wr_hold and FIFO non-empty: WrEn<=1, Aw/Dw<=head, pop.
  - Else: WrEn<=0, and Aw/Dw hold their previous values.
- Latency:
  - Accepted at edge N into an empty FIFO -> WrEn=1 during cycle N+1 -> register file commits at edge N+2.
  - Sustained throughput is one write per cycle.
- Ordering: commits are strictly in acceptance order. Same-address writes commit oldest first, so the youngest value wins.
- Simultaneous push and pop: fifo_count is unchanged. Push into a full FIFO cannot occur.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges from 0 to FIFO_DEPTH.
- The requester must hold valid/addr/data stable until ready. The block does not check this.

Optional Feature:
- Macro: REGFILE_WR_ARB_FWD_EN
- Defined:
  - chk_pending=1 when chk_addr!=0 and it matches any valid FIFO entry, or matches Aw while WrEn=1.
  - chk_data = data of the youngest match (FIFO tail-most first, output register last); 0 when no match.
  - Both outputs are purely combinational from current state.
- Undefined: chk_pending=0 and chk_data=0 constantly; chk_addr is ignored.

Decomposition:
- Shared package regfile_pkg:
  - ADDR_W/DATA_W constants.
  - Register-0 address constant.
  - Write-request struct typedef {addr, data}.
  - Requester-id enum {REQ_A, REQ_B}.
- One natural sub-module, wr_fifo: parameterised sync FIFO with push/pop/count/full/empty. Its entry contents are exposed for the forwarding compare.
- Arbiter, discard logic and output register remain in the top level.

Test Plan:
- Single write: A writes addr 4, data 69; B idle -> a_ready=1; next cycle WrEn=1, Aw=4, Dw=69; register file then reads Da=69.
- Contention: A (addr 1, data 11) and B (addr 2, data 22) valid for 4 cycles -> grants A,B,A,B; WrEn stream Aw=1,2,1,2 in order.
- Zero discard: A writes addr 0, data 69 -> a_ready=1, fifo_count stays 0, WrEn never rises; a register-file read of 0 returns 0.
- Hold/full:
  - wr_hold=1; push addr 25 data 420, then addr 25 data 42 -> fifo_count=2, both readies 0.
  - Release hold -> two consecutive WrEn cycles: Dw=420 then Dw=42; final read returns 42.
- Reset mid-op: FIFO holding 2 entries; assert reset one cycle -> WrEn=0, fifo_count=0, no later writes; next contested cycle grants A.
- Forwarding (with macro): pending write addr 7, data 5 followed by addr 7, data 9 -> chk_addr=7 gives chk_pending=1, chk_data=9. With chk_addr=0 -> chk_pending=0. Without macro -> chk_pending=0 throughout.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter: widths, the $zero
// address, the pending-write record and requester ids.
package regfile_pkg;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int REG_ZERO   = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/regfile_write_arbiter_wr_fifo.sv
// In-order synchronous FIFO for pending register writes; entry storage and the
// read pointer are exported so the top level can search for address matches.
module wr_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty,
    output logic [PTR_W-1:0]       rd_ptr,
    output logic [DEPTH*WIDTH-1:0] entries
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        entries = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries[i*WIDTH +: WIDTH] = mem[i];
        end
    end

    // Storage carries no reset; occupancy is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port between ALU (A) and load (B)
// writeback, through an in-order FIFO and a registered port stage.
// Optional hazard-check forwarding is enabled by defining REGFILE_WR_ARB_FWD_EN.
module regfile_write_arbiter #(
    parameter int ADDR_W     = regfile_pkg::ADDR_W,
    parameter int DATA_W     = regfile_pkg::DATA_W,
    parameter int FIFO_DEPTH = regfile_pkg::FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [ADDR_W-1:0]             a_addr,
    input  logic [DATA_W-1:0]             a_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [ADDR_W-1:0]             b_addr,
    input  logic [DATA_W-1:0]             b_data,
    input  logic                          wr_hold,
    output logic                          WrEn,
    output logic [ADDR_W-1:0]             Aw,
    output logic [DATA_W-1:0]             Dw,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic [ADDR_W-1:0]             chk_addr,
    output logic                          chk_pending,
    output logic [DATA_W-1:0]             chk_data
);

    import regfile_pkg::*;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REQ_W = ADDR_W + DATA_W;

    req_id_t                   last_grant;
    logic                      grant_a;
    logic                      grant_b;
    logic                      push;
    logic                      pop;
    logic [ADDR_W-1:0]         sel_addr;
    logic [DATA_W-1:0]         sel_data;
    logic [REQ_W-1:0]          fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [PTR_W-1:0]          fifo_rd_ptr;
    logic [FIFO_DEPTH*REQ_W-1:0] fifo_mem;

    // valid/ready: a write transfers at a posedge where valid && ready. ready is
    // a function of both valids, last_grant and FIFO fullness only, so it never
    // sees wr_hold or the same-cycle pop. Requesters hold valid/addr/data until ready.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!fifo_full) begin
            if (a_valid && (!b_valid || last_grant == REQ_B)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign sel_addr = grant_a ? a_addr : b_addr;
    assign sel_data = grant_a ? a_data : b_data;

    // Register-0 writes are consumed here and never reach the FIFO.
    assign push = (grant_a || grant_b) && (sel_addr != ADDR_W'(REG_ZERO));
    assign pop  = !wr_hold && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_B;
        end else if (grant_a) begin
            last_grant <= REQ_A;
        end else if (grant_b) begin
            last_grant <= REQ_B;
        end
    end

    wr_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({sel_addr, sel_data}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .rd_ptr    (fifo_rd_ptr),
        .entries   (fifo_mem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            WrEn <= 1'b0;
            Aw   <= '0;
            Dw   <= '0;
        end else if (pop) begin
            WrEn <= 1'b1;
            Aw   <= fifo_head[REQ_W-1:DATA_W];
            Dw   <= fifo_head[DATA_W-1:0];
        end else begin
            WrEn <= 1'b0;
        end
    end

`ifdef REGFILE_WR_ARB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;
    logic [REQ_W-1:0] fwd_entry;

    // The port register is older than anything queued, so it is checked first and
    // FIFO entries overwrite it walking oldest to youngest.
    always_comb begin
        chk_pending = 1'b0;
        chk_data    = '0;
        fwd_idx     = '0;
        fwd_entry   = '0;
        if (chk_addr != ADDR_W'(REG_ZERO)) begin
            if (WrEn && (Aw == chk_addr)) begin
                chk_pending = 1'b1;
                chk_data    = Dw;
            end
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (CNT_W'(k) < fifo_count) begin
                    fwd_idx   = fifo_rd_ptr + PTR_W'(k);
                    fwd_entry = fifo_mem[int'(fwd_idx)*REQ_W +: REQ_W];
                    if (fwd_entry[REQ_W-1:DATA_W] == chk_addr) begin
                        chk_pending = 1'b1;
                        chk_data    = fwd_entry[DATA_W-1:0];
                    end
                end
            end
        end
    end
`else
    logic unused_fwd;

    assign chk_pending = 1'b0;
    assign chk_data    = '0;
    assign unused_fwd  = ^{chk_addr, fifo_mem, fifo_rd_ptr};
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a register-file model on the write
// port, an expected-write queue for the commit stream, and immediate assertions.
module tb_regfile_write_arbiter;

    import regfile_pkg::*;

    localparam int W = $bits(wr_req_t);
`ifdef REGFILE_WR_ARB_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              wr_hold;
    logic              WrEn;
    logic [ADDR_W-1:0] Aw;
    logic [DATA_W-1:0] Dw;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_pending;
    logic [DATA_W-1:0] chk_data;

    logic [DATA_W-1:0] rf [32];
    logic [W-1:0]      exp_q [$];
    logic [W-1:0]      exp_w;
    int                vectors;
    int                miscompares;

    regfile_write_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .wr_hold     (wr_hold),
        .WrEn        (WrEn),
        .Aw          (Aw),
        .Dw          (Dw),
        .fifo_count  (fifo_count),
        .chk_addr    (chk_addr),
        .chk_pending (chk_pending),
        .chk_data    (chk_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register-file model; $zero is hardwired
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (WrEn && Aw != '0) begin
            rf[Aw] <= Dw;
        end
    end

    function automatic logic [W-1:0] mk(input int addr, input int data);
        wr_req_t r;
        r.addr = ADDR_W'(addr);
        r.data = DATA_W'(data);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one clock; every committed write is matched against the expected queue
    task automatic cyc();
        @(posedge clk);
        #1;
        if (WrEn === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_write observed Aw=%0d Dw=%0d expected no write", Aw, Dw);
            end
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check("write_stream", 64'({Aw, Dw}), 64'(exp_w));
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        wr_hold  = 1'b0;
        chk_addr = '0;
        exp_q.delete();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; wr_hold = 1'b0;
        a_addr = '0; a_data = '0; b_addr = '0; b_data = '0; chk_addr = '0;
        do_reset();
        do_reset();

        // reset state
        check("rst_wren", WrEn, 0);
        check("rst_aw", Aw, 0);
        check("rst_dw", Dw, 0);
        check("rst_count", fifo_count, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_chk_pending", chk_pending, 0);

        // single write: accept, WrEn one cycle later, commit the cycle after
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'd69;
        #1;
        check("single_a_ready", a_ready, 1);
        check("single_b_ready", b_ready, 0);
        exp_q.push_back(mk(4, 69));
        cyc();
        a_valid = 1'b0;
        check("single_count", fifo_count, 1);
        check("single_wren_early", WrEn, 0);
        cyc();
        check("single_wren", WrEn, 1);
        check("single_aw", Aw, 4);
        check("single_dw", Dw, 69);
        check("single_count_pop", fifo_count, 0);
        cyc();
        check("single_wren_off", WrEn, 0);
        check("single_aw_hold", Aw, 4);
        check("single_rf", rf[4], 69);

        // contention: grants alternate A,B,A,B
        do_reset();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'd11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'd22;
        exp_q.push_back(mk(1, 11));
        exp_q.push_back(mk(2, 22));
        exp_q.push_back(mk(1, 11));
        exp_q.push_back(mk(2, 22));
        for (int i = 0; i < 4; i++) begin
            #1;
            check("contend_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            check("contend_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
            cyc();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        cyc();
        cyc();
        check("contend_drained", exp_q.size(), 0);
        check("contend_rf1", rf[1], 11);
        check("contend_rf2", rf[2], 22);

        // zero discard: accepted, never queued, still counts as A's grant
        do_reset();
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'd69;
        #1;
        check("zero_a_ready", a_ready, 1);
        cyc();
        a_valid = 1'b0;
        check("zero_count", fifo_count, 0);
        cyc();
        check("zero_wren", WrEn, 0);
        check("zero_rf", rf[0], 0);
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'd55;
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'd33;
        #1;
        check("zero_then_b_ready", b_ready, 1);
        check("zero_then_a_ready", a_ready, 0);
        exp_q.push_back(mk(3, 33));
        exp_q.push_back(mk(5, 55));
        cyc();
        b_valid = 1'b0;
        #1;
        check("zero_then_a_ready2", a_ready, 1);
        cyc();
        a_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        check("zero_drained", exp_q.size(), 0);
        check("zero_rf3", rf[3], 33);
        check("zero_rf5", rf[5], 55);

        // hold until full, then release: both same-address writes, oldest first
        do_reset();
        wr_hold = 1'b1;
        a_valid = 1'b1; a_addr = 5'd25; a_data = 32'd420;
        #1;
        check("hold_a_ready1", a_ready, 1);
        cyc();
        a_data = 32'd42;
        #1;
        check("hold_a_ready2", a_ready, 1);
        cyc();
        a_valid = 1'b0;
        check("hold_count_full", fifo_count, 2);
        check("hold_wren", WrEn, 0);
        a_valid = 1'b1; b_valid = 1'b1; b_addr = 5'd9; b_data = 32'd99;
        #1;
        check("full_a_ready", a_ready, 0);
        check("full_b_ready", b_ready, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        cyc();
        check("hold_count_stay", fifo_count, 2);
        check("hold_wren_stay", WrEn, 0);
        exp_q.push_back(mk(25, 420));
        exp_q.push_back(mk(25, 42));
        wr_hold = 1'b0;
        cyc();
        check("release_wren1", WrEn, 1);
        check("release_dw1", Dw, 420);
        check("release_count1", fifo_count, 1);
        cyc();
        check("release_wren2", WrEn, 1);
        check("release_dw2", Dw, 42);
        check("release_count2", fifo_count, 0);
        cyc();
        check("release_wren_off", WrEn, 0);
        check("release_rf25", rf[25], 42);

        // reset mid-operation drops queued writes and restores last_grant
        do_reset();
        wr_hold = 1'b1;
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'd100;
        cyc();
        a_addr = 5'd11; a_data = 32'd111;
        cyc();
        a_valid = 1'b0;
        check("midrst_count_before", fifo_count, 2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wr_hold = 1'b0;
        check("midrst_wren", WrEn, 0);
        check("midrst_count", fifo_count, 0);
        cyc();
        cyc();
        check("midrst_wren_later", WrEn, 0);
        check("midrst_rf10", rf[10], 0);
        check("midrst_rf11", rf[11], 0);
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'd120;
        b_valid = 1'b1; b_addr = 5'd13; b_data = 32'd130;
        #1;
        check("midrst_grant_a", a_ready, 1);
        check("midrst_grant_b", b_ready, 0);
        exp_q.push_back(mk(12, 120));
        cyc();
        a_valid = 1'b0; b_valid = 1'b0;
        cyc();
        cyc();
        check("midrst_drained", exp_q.size(), 0);
        check("midrst_rf12", rf[12], 120);

        // hazard check: youngest pending value for the probed address
        do_reset();
        wr_hold = 1'b1;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'd5;
        cyc();
        a_data = 32'd9;
        cyc();
        a_valid = 1'b0;
        chk_addr = 5'd7;
        #1;
        check("fwd_pending_q", chk_pending, FWD ? 1 : 0);
        check("fwd_data_q", chk_data, FWD ? 9 : 0);
        chk_addr = 5'd0;
        #1;
        check("fwd_zero_pending", chk_pending, 0);
        check("fwd_zero_data", chk_data, 0);
        chk_addr = 5'd8;
        #1;
        check("fwd_miss_pending", chk_pending, 0);
        chk_addr = 5'd7;
        exp_q.push_back(mk(7, 5));
        exp_q.push_back(mk(7, 9));
        wr_hold = 1'b0;
        cyc();
        check("fwd_pending_mix", chk_pending, FWD ? 1 : 0);
        check("fwd_data_mix", chk_data, FWD ? 9 : 0);
        cyc();
        check("fwd_pending_port", chk_pending, FWD ? 1 : 0);
        check("fwd_data_port", chk_data, FWD ? 9 : 0);
        cyc();
        check("fwd_pending_done", chk_pending, 0);
        check("fwd_data_done", chk_data, 0);
        check("fwd_rf7", rf[7], 9);

        check("final_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
